// File: rtl/rgmii_cal_pkg.sv
// Shared types and constants for the RGMII RX input-delay calibrator.
// Lane layout of a capture word is {ctl, d[3:0]}.
package rgmii_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    OBSERVE,
    EVAL,
    FINAL
  } state_t;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam int RGMII_LANES = 5;

  function automatic logic is_pre(
    input logic [RGMII_LANES-1:0] q
  );
    return q == {1'b1, PREAMBLE_NIB};
  endfunction

endpackage

// File: rtl/rgmii_rx_idelay_cal_window.sv
// Scoring window for one tap: registered hit/err detect,
// cycle counter, saturating hit counter and sticky error flag.
module rgmii_cal_window
  import rgmii_cal_pkg::*;
#(
  parameter int OBS_CYC  = 4096,
  parameter int MIN_HITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   run,
  input  logic [RGMII_LANES-1:0] q1,
  input  logic [RGMII_LANES-1:0] q2,
  output logic                   expired,
  output logic                   hit_ok,
  output logic                   err_flag
);

  localparam int CW = $clog2(OBS_CYC + 1);
  localparam int HW = $clog2(MIN_HITS + 2);
  localparam logic [CW-1:0] CYC_LAST = CW'(OBS_CYC - 1);
  localparam logic [HW-1:0] HIT_MAX = HW'(MIN_HITS);

  logic          hit_r;
  logic          err_r;
  logic [CW-1:0] cyc;
  logic [HW-1:0] hit_cnt;

  assign expired = run && (cyc == CYC_LAST);
  assign hit_ok  = (hit_cnt >= HIT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      hit_r <= is_pre(q1) && is_pre(q2);
      err_r <= q1[4] ^ q2[4];
    end
  end

  // cycle 0 of a run holds a stale sample from settling
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cyc      <= '0;
      hit_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (run) begin
      cyc <= expired ? '0 : cyc + CW'(1);
      if (cyc != '0) begin
        if (hit_r && hit_cnt != HIT_MAX)
          hit_cnt <= hit_cnt + HW'(1);
        if (err_r)
          err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgmii_rx_idelay_cal.sv
// Sweeps the RX IDELAY tap, scores each tap on preamble hits and
// ctl errors, then loads the centre of the longest passing run.
module rgmii_rx_idelay_cal
  import rgmii_cal_pkg::*;
#(
  parameter int TAP_W       = 5,
  parameter int DEFAULT_TAP = 12,
  parameter int SETTLE_CYC  = 16,
  parameter int OBS_CYC     = 4096,
  parameter int MIN_HITS    = 8,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [RGMII_LANES-1:0] q1,
  input  logic [RGMII_LANES-1:0] q2,
  output logic [TAP_W-1:0]       tap_val,
  output logic                   tap_ld,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [TAP_W:0]         best_len
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_MAX = '1;
  localparam logic [TAP_W-1:0] TAP_DEF = TAP_W'(DEFAULT_TAP);

  state_t           state;
  logic [TAP_W-1:0] tap;
  logic [TAP_W-1:0] run_start;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   run_len;
  logic [SW-1:0]    set_cnt;

  logic             expired;
  logic             hit_ok;
  logic             err_flag;
  logic             good;
  logic [TAP_W:0]   run_nxt;
  logic [TAP_W-1:0] start_nxt;
  logic [TAP_W:0]   half;
  logic [TAP_W-1:0] centre;

  rgmii_cal_window #(
    .OBS_CYC  (OBS_CYC),
    .MIN_HITS (MIN_HITS)
  ) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == LOAD),
    .run      (state == OBSERVE),
    .q1       (q1),
    .q2       (q2),
    .expired  (expired),
    .hit_ok   (hit_ok),
    .err_flag (err_flag)
  );

  always_comb begin
    good      = hit_ok && !err_flag;
    run_nxt   = good ? run_len + 1'b1 : '0;
    start_nxt = (good && run_len == '0) ? tap : run_start;
    half      = (best_len - 1'b1) >> 1;
    centre    = best_start + half[TAP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= AUTO_START ? LOAD : IDLE;
      tap        <= '0;
      tap_val    <= TAP_DEF;
      tap_ld     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      best_len   <= '0;
      best_start <= '0;
      run_len    <= '0;
      run_start  <= '0;
      set_cnt    <= '0;
    end else begin
      tap_ld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            tap      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            fail     <= 1'b0;
            best_len <= '0;
            run_len  <= '0;
          end
        end
        LOAD: begin
          tap_val <= tap;
          tap_ld  <= 1'b1;
          busy    <= 1'b1;
          set_cnt <= '0;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (set_cnt == SET_LAST)
            state <= OBSERVE;
          else
            set_cnt <= set_cnt + SW'(1);
        end
        OBSERVE: begin
          if (expired)
            state <= EVAL;
        end
        EVAL: begin
          run_len   <= run_nxt;
          run_start <= start_nxt;
          // strict compare keeps the earlier run on a tie
          if (run_nxt > best_len) begin
            best_len   <= run_nxt;
            best_start <= start_nxt;
          end
          if (tap == TAP_MAX) begin
            state <= FINAL;
          end else begin
            tap   <= tap + 1'b1;
            state <= LOAD;
          end
        end
        FINAL: begin
          tap_ld <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
          if (best_len != '0) begin
            tap_val <= centre;
            done    <= 1'b1;
          end else begin
            tap_val <= TAP_DEF;
            fail    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx_idelay_cal.sv
// Bench for rgmii_rx_idelay_cal: eye model driven from tap_val,
// tap sequence scoreboard and table of calibration outcomes.
module tb_rgmii_rx_idelay_cal;

  localparam int SET  = 4;
  localparam int OBS  = 32;
  localparam int MINH = 8;
  localparam int DEF  = 12;
  localparam int NTAP = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] q1;
  logic [4:0] q2;

  logic [4:0] tap_val;
  logic       tap_ld;
  logic       busy;
  logic       done;
  logic       fail;
  logic [5:0] best_len;

  logic [4:0] tap_val_a;
  logic       tap_ld_a;
  logic       busy_a;
  logic       done_a;
  logic       fail_a;
  logic [5:0] best_len_a;

  rgmii_rx_idelay_cal #(
    .TAP_W(5), .DEFAULT_TAP(DEF), .SETTLE_CYC(SET),
    .OBS_CYC(OBS), .MIN_HITS(MINH), .AUTO_START(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .q1(q1), .q2(q2),
    .tap_val(tap_val), .tap_ld(tap_ld), .busy(busy),
    .done(done), .fail(fail), .best_len(best_len)
  );

  rgmii_rx_idelay_cal #(
    .TAP_W(5), .DEFAULT_TAP(DEF), .SETTLE_CYC(SET),
    .OBS_CYC(OBS), .MIN_HITS(MINH), .AUTO_START(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(1'b0),
    .q1(q1), .q2(q2),
    .tap_val(tap_val_a), .tap_ld(tap_ld_a), .busy(busy_a),
    .done(done_a), .fail(fail_a), .best_len(best_len_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    bit          errs;
    int          inj;
    bit          mid_start;
    bit          e_done;
    bit          e_fail;
    int          e_len;
    int          e_tap;
  } vec_t;

  logic [31:0] mask = '0;
  bit          errs = 1'b0;
  int          inj = -1;
  int          since = 0;
  int          total = 0;
  int          bad = 0;
  int          ld_cnt = 0;
  int          exp_q[$];
  vec_t        res_q[$];
  vec_t        vecs[6];

  // eye model: lanes depend on the tap currently loaded
  always_comb begin
    q1 = 5'h00;
    q2 = 5'h00;
    if (int'(tap_val) == inj && since == SET + OBS / 2) begin
      q1 = 5'h15;
      q2 = 5'h05;
    end else if (mask[tap_val]) begin
      q1 = 5'h15;
      q2 = 5'h15;
    end else if (errs) begin
      q1 = 5'h10;
      q2 = 5'h00;
    end
  end

  always @(posedge clk) since <= tap_ld ? 0 : since + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tap_ld) begin
        ld_cnt++;
        if (exp_q.size() == 0) begin
          chk("tap_ld_unexpected", int'(tap_val), -1);
        end else begin
          chk("tap_seq", int'(tap_val), exp_q.pop_front());
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_cal(input vec_t v);
    vec_t r;
    int   n;
    mask = v.mask;
    errs = v.errs;
    inj  = v.inj;
    for (int t = 0; t < NTAP; t++) exp_q.push_back(t);
    exp_q.push_back(v.e_tap);
    res_q.push_back(v);
    ld_cnt = 0;
    pulse_start();
    chk("busy_rise", int'(busy), 1);
    if (v.mid_start) begin
      repeat (100) @(negedge clk);
      pulse_start();
    end
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("cal_timeout", int'(busy), 0);
    repeat (2) @(negedge clk);
    r = res_q.pop_front();
    chk("done", int'(done), int'(r.e_done));
    chk("fail", int'(fail), int'(r.e_fail));
    chk("best_len", int'(best_len), r.e_len);
    chk("final_tap", int'(tap_val), r.e_tap);
    chk("ld_count", ld_cnt, NTAP + 1);
    chk("ld_left", exp_q.size(), 0);
    exp_q.delete();
    inj = -1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tap_val"}, int'(tap_val), DEF);
    chk({tag, "_tap_ld"}, int'(tap_ld), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_best_len"}, int'(best_len), 0);
  endtask

  initial begin
    int n;
    int ld0;
    vecs[0] = '{32'hFFFF_FFFF, 1'b0, -1, 1'b0, 1'b1, 1'b0, 32, 15};
    vecs[1] = '{32'h001F_FE00, 1'b1, -1, 1'b0, 1'b1, 1'b0, 12, 14};
    vecs[2] = '{32'h00F0_0078, 1'b0, -1, 1'b0, 1'b1, 1'b0, 4, 4};
    vecs[3] = '{32'hFFF0_000F, 1'b0, -1, 1'b0, 1'b1, 1'b0, 12, 25};
    vecs[4] = '{32'h0000_0000, 1'b0, -1, 1'b0, 1'b0, 1'b1, 0, DEF};
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 10, 1'b1, 1'b1, 1'b0, 21, 21};

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("auto_rst_ld", int'(tap_ld_a), 0);
    chk("auto_rst_busy", int'(busy_a), 0);
    chk("auto_rst_tap", int'(tap_val_a), DEF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("auto_first_ld", int'(tap_ld_a), 1);
    chk("auto_first_tap", int'(tap_val_a), 0);
    chk("auto_busy", int'(busy_a), 1);
    chk("manual_no_ld", int'(tap_ld), 0);
    chk("manual_idle", int'(busy), 0);

    for (int i = 0; i < 6; i++) run_cal(vecs[i]);

    // reset in the middle of tap 7's window
    mask = 32'hFFFF_FFFF;
    errs = 1'b0;
    for (int t = 0; t < 8; t++) exp_q.push_back(t);
    pulse_start();
    n = 0;
    while (!(tap_val == 5'd7 && since == SET + 5) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_tap7", int'(tap_val), 7);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("midrst");
    chk("pre_reset_lds", exp_q.size(), 0);
    exp_q.delete();
    ld0 = ld_cnt;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_ld_after_rst", ld_cnt, ld0);
    chk("idle_after_rst", int'(busy), 0);
    run_cal(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
